// File: rtl/button_event_if.sv
// Button event bus: tick and button level in, registered level plus one-cycle event pulses out.
interface button_event_if;
  logic en_i;
  logic in;
  logic pressed_o;
  logic press_o;
  logic release_o;
  logic short_o;
  logic double_o;
  logic long_o;
  logic repeat_o;

  modport master (
    output en_i, in,
    input  pressed_o, press_o, release_o, short_o, double_o, long_o, repeat_o
  );

  modport slave (
    input  en_i, in,
    output pressed_o, press_o, release_o, short_o, double_o, long_o, repeat_o
  );
endinterface

// File: rtl/button_event.sv
// Classifies a debounced button into press/release edges and short, double, long and repeat gestures,
// timed in en_i ticks. Every output is registered one cycle after the sampling edge.
module button_event #(
  parameter int LONG_EN_COUNT   = 16,
  parameter int GAP_EN_COUNT    = 8,
  parameter int REPEAT_EN_COUNT = 4
) (
  input logic clk,
  input logic rst_n,
  button_event_if.slave bus
);

  localparam int MAX_LG  = (LONG_EN_COUNT > GAP_EN_COUNT) ? LONG_EN_COUNT : GAP_EN_COUNT;
  localparam int MAX_CNT = (MAX_LG > REPEAT_EN_COUNT) ? MAX_LG : REPEAT_EN_COUNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_EN_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EN_COUNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_EN_COUNT - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             in_q;
  logic             rise, fall;
  logic             long_hit, gap_hit, rep_hit;

  logic press_p0, release_p0, short_p0, double_p0, long_p0, repeat_p0;
  logic press_p1, release_p1, short_p1, double_p1, long_p1, repeat_p1;

  assign rise     = bus.in & ~in_q;
  assign fall     = ~bus.in & in_q;
  assign long_hit = bus.en_i && (cnt == LONG_LAST);
  assign gap_hit  = bus.en_i && (cnt == GAP_LAST);
  assign rep_hit  = bus.en_i && (cnt == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      in_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      in_q  <= bus.in;
    end
  end

  // Edges take priority over thresholds; out-of-place edges simply fall through.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (rise) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (fall)          state_nxt = GAP;
        else if (long_hit) state_nxt = HELD;
        else if (bus.en_i) cnt_nxt   = cnt + CNT_W'(1);
      end
      GAP: begin
        if (rise)          state_nxt = PRESS2;
        else if (gap_hit)  state_nxt = IDLE;
        else if (bus.en_i) cnt_nxt   = cnt + CNT_W'(1);
      end
      PRESS2: begin
        if (fall)          state_nxt = IDLE;
        else if (long_hit) state_nxt = HELD;
        else if (bus.en_i) cnt_nxt   = cnt + CNT_W'(1);
      end
      HELD: begin
        if (fall)          state_nxt = IDLE;
        else if (rep_hit)  cnt_nxt   = '0;
        else if (bus.en_i) cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_comb begin
    press_p0   = 1'b0;
    release_p0 = 1'b0;
    short_p0   = 1'b0;
    double_p0  = 1'b0;
    long_p0    = 1'b0;
    repeat_p0  = 1'b0;
    case (state)
      IDLE: press_p0 = rise;
      PRESS1: begin
        release_p0 = fall;
        long_p0    = !fall && long_hit;
      end
      GAP: begin
        press_p0 = rise;
        short_p0 = !rise && gap_hit;
      end
      PRESS2: begin
        release_p0 = fall;
        double_p0  = fall;
        short_p0   = !fall && long_hit;
        long_p0    = !fall && long_hit;
      end
      HELD: begin
        release_p0 = fall;
        repeat_p0  = !fall && rep_hit;
      end
      default: ;
    endcase
  end

  // p0 -> p1: event pulses registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_p1   <= 1'b0;
      release_p1 <= 1'b0;
      short_p1   <= 1'b0;
      double_p1  <= 1'b0;
      long_p1    <= 1'b0;
      repeat_p1  <= 1'b0;
    end else begin
      press_p1   <= press_p0;
      release_p1 <= release_p0;
      short_p1   <= short_p0;
      double_p1  <= double_p0;
      long_p1    <= long_p0;
      repeat_p1  <= repeat_p0;
    end
  end

  assign bus.pressed_o = in_q;
  assign bus.press_o   = press_p1;
  assign bus.release_o = release_p1;
  assign bus.short_o   = short_p1;
  assign bus.double_o  = double_p1;
  assign bus.long_o    = long_p1;
  assign bus.repeat_o  = repeat_p1;

endmodule
